// File: rtl/rr_arbiter_lock.sv
// N-way round-robin arbiter with wormhole packet locking and an optional
// per-ownership hold limit that forces the owner to release the output.
module rr_arbiter_lock #(
    parameter int N_REQ    = 4,
    parameter int IDX_W    = $clog2(N_REQ),
    parameter int MAX_HOLD = 0
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] lock_i,
    input  logic             update_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_valid_o,
    output logic             locked_o,
    output logic             forced_release_o
);

    // Unlimited mode keeps a 16-bit saturating counter; otherwise the counter
    // is just wide enough to reach MAX_HOLD without wrapping.
    localparam int HOLD_W = (MAX_HOLD == 0) ? 16 : $clog2(MAX_HOLD + 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            st_q, st_d;
    logic [N_REQ-1:0]  mask_q, mask_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              frc_q, frc_d;

    logic [N_REQ-1:0]  masked;
    logic [IDX_W-1:0]  masked_idx;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  idle_idx;
    logic              masked_any;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_vld;
    logic              accept;

    // Priority pick: lowest masked requester first, falling back to the lowest
    // raw requester so the search wraps around after the last grant.
    always_comb begin
        masked     = req_i & mask_q;
        masked_any = |masked;
        masked_idx = '0;
        req_idx    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (masked[i]) begin
                masked_idx = IDX_W'(i);
            end
            if (req_i[i]) begin
                req_idx = IDX_W'(i);
            end
        end
        idle_idx = masked_any ? masked_idx : req_idx;
    end

    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        if (!arst) begin
            if (st_q == ST_LOCKED) begin
                gnt_idx = owner_q;
                gnt_vld = req_i[owner_q];
            end else begin
                gnt_idx = idle_idx;
                gnt_vld = |req_i;
            end
        end
    end

    assign accept = update_i & gnt_vld;

    always_comb begin
        st_d    = st_q;
        mask_d  = mask_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        frc_d   = 1'b0;
        if (accept) begin
            case (st_q)
                ST_IDLE: begin
                    for (int k = 0; k < N_REQ; k++) begin
                        mask_d[k] = (k > int'(gnt_idx));
                    end
                    // A one-beat hold limit would release immediately, so never lock.
                    if (lock_i[gnt_idx] && (MAX_HOLD != 1)) begin
                        st_d    = ST_LOCKED;
                        owner_d = gnt_idx;
                        hold_d  = HOLD_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!lock_i[owner_q]) begin
                        st_d   = ST_IDLE;
                        hold_d = '0;
                    end else if ((MAX_HOLD != 0) && (int'(hold_q) + 1 == MAX_HOLD)) begin
                        st_d   = ST_IDLE;
                        hold_d = '0;
                        frc_d  = 1'b1;
                    end else if (!((MAX_HOLD == 0) && (&hold_q))) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                default: begin
                    st_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            st_q    <= ST_IDLE;
            mask_q  <= '1;
            owner_q <= '0;
            hold_q  <= '0;
            frc_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            mask_q  <= mask_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            frc_q   <= frc_d;
        end
    end

    assign grant_o          = gnt_vld ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
    assign grant_idx_o      = gnt_vld ? gnt_idx : '0;
    assign grant_valid_o    = gnt_vld;
    assign locked_o         = !arst && (st_q == ST_LOCKED);
    assign forced_release_o = !arst && frc_q;

    a_onehot : assert property (@(posedge clk) $onehot0(grant_o));
    a_valid  : assert property (@(posedge clk) grant_valid_o == (|grant_o));

endmodule

// File: tb/tb_rr_arbiter_lock.sv
// Bench for rr_arbiter_lock: two instances (unlimited hold and MAX_HOLD=2)
// share stimulus; a circular-pointer reference model feeds expected queues.
module tb_rr_arbiter_lock;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int EW = N + IW + 3;

    logic         clk = 1'b0;
    logic         arst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] lock = '0;
    logic         upd = 1'b0;

    logic [N-1:0]  g0, g1;
    logic [IW-1:0] gi0, gi1;
    logic          gv0, gv1, lk0, lk1, fr0, fr1;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp2_q[$];

    int checks = 0;
    int passes = 0;

    // Reference model state: next search start, lock status, owner, beat count.
    int m_ptr[2];
    bit m_lk[2];
    int m_own[2];
    int m_hold[2];
    bit m_frc[2];
    int m_pick[2];
    bit m_vld[2];
    int maxh[2] = '{0, 2};

    always #5 clk = ~clk;

    rr_arbiter_lock #(.N_REQ(N), .MAX_HOLD(0)) dut (
        .clk(clk), .arst(arst), .req_i(req), .lock_i(lock), .update_i(upd),
        .grant_o(g0), .grant_idx_o(gi0), .grant_valid_o(gv0),
        .locked_o(lk0), .forced_release_o(fr0)
    );

    rr_arbiter_lock #(.N_REQ(N), .MAX_HOLD(2)) dut_h (
        .clk(clk), .arst(arst), .req_i(req), .lock_i(lock), .update_i(upd),
        .grant_o(g1), .grant_idx_o(gi1), .grant_valid_o(gv1),
        .locked_o(lk1), .forced_release_o(fr1)
    );

    task automatic model_eval(input int c, output logic [EW-1:0] e);
        logic [N-1:0] g;
        int idx;
        bit v;
        g = '0;
        idx = 0;
        v = 1'b0;
        if (!arst) begin
            if (m_lk[c]) begin
                v = req[m_own[c]];
                idx = m_own[c];
            end else begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr[c] + k) % N;
                    if (!v && req[j]) begin
                        v = 1'b1;
                        idx = j;
                    end
                end
            end
        end
        if (v) g[idx] = 1'b1;
        else idx = 0;
        m_pick[c] = idx;
        m_vld[c] = v;
        e = {g, IW'(idx), v, (!arst && m_lk[c]), (!arst && m_frc[c])};
    endtask

    task automatic model_step(input int c);
        bit f;
        f = 1'b0;
        if (arst) begin
            m_ptr[c] = 0; m_lk[c] = 0; m_own[c] = 0; m_hold[c] = 0; m_frc[c] = 0;
        end else begin
            if (upd && m_vld[c]) begin
                if (!m_lk[c]) begin
                    m_ptr[c] = (m_pick[c] + 1) % N;
                    if (lock[m_pick[c]] && maxh[c] != 1) begin
                        m_lk[c] = 1; m_own[c] = m_pick[c]; m_hold[c] = 1;
                    end
                end else if (!lock[m_own[c]]) begin
                    m_lk[c] = 0; m_hold[c] = 0;
                end else if (maxh[c] != 0 && m_hold[c] + 1 == maxh[c]) begin
                    m_lk[c] = 0; m_hold[c] = 0; f = 1;
                end else begin
                    m_hold[c] = m_hold[c] + 1;
                end
            end
            m_frc[c] = f;
        end
    endtask

    task automatic drive(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                         input logic u);
        logic [EW-1:0] e0, e1;
        @(negedge clk);
        arst = r;
        req = rq;
        lock = lk;
        upd = u;
        model_eval(0, e0);
        model_eval(1, e1);
        exp_q.push_back(e0);
        exp2_q.push_back(e1);
        model_step(0);
        model_step(1);
    endtask

    // Monitor: compare each cycle's outputs against the queued expectation.
    initial begin
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {g0, gi0, gv0, lk0, fr0};
                checks++;
                if (a === e) passes++;
                else $display("FAIL arb_unlimited t=%0t got=%b exp=%b (grant,idx,valid,locked,frc)", $time, a, e);
            end
            if (exp2_q.size() > 0) begin
                e = exp2_q.pop_front();
                a = {g1, gi1, gv1, lk1, fr1};
                checks++;
                if (a === e) passes++;
                else $display("FAIL arb_hold2 t=%0t got=%b exp=%b (grant,idx,valid,locked,frc)", $time, a, e);
            end
        end
    end

    initial begin
        for (int c = 0; c < 2; c++) begin
            m_ptr[c] = 0; m_lk[c] = 0; m_own[c] = 0; m_hold[c] = 0; m_frc[c] = 0;
            m_pick[c] = 0; m_vld[c] = 0;
        end

        drive(1, 4'b1111, 4'b0000, 1);
        drive(1, 4'b0000, 4'b0000, 0);
        for (int i = 0; i < 5; i++) drive(0, 4'b1111, 4'b0000, 1);

        drive(1, 4'b0000, 4'b0000, 0);
        for (int i = 0; i < 3; i++) drive(0, 4'b1010, 4'b0000, 1);
        drive(0, 4'b0000, 4'b0000, 1);
        drive(0, 4'b1010, 4'b0000, 1);

        drive(1, 4'b0000, 4'b0000, 0);
        drive(0, 4'b0011, 4'b0001, 1);
        drive(0, 4'b0011, 4'b0001, 1);
        drive(0, 4'b0010, 4'b0001, 1);
        drive(0, 4'b0010, 4'b0001, 1);
        drive(0, 4'b0011, 4'b0001, 1);
        drive(0, 4'b0011, 4'b0000, 1);
        drive(0, 4'b0011, 4'b0000, 1);
        drive(0, 4'b0011, 4'b0000, 0);

        drive(1, 4'b0000, 4'b0000, 0);
        drive(0, 4'b0011, 4'b0001, 1);
        drive(0, 4'b0011, 4'b0001, 1);
        drive(0, 4'b0011, 4'b0001, 1);
        drive(0, 4'b0011, 4'b0001, 1);

        drive(1, 4'b0000, 4'b0000, 0);
        drive(0, 4'b0100, 4'b0100, 1);
        drive(0, 4'b0100, 4'b0100, 0);
        drive(1, 4'b0110, 4'b0100, 1);
        drive(1, 4'b0110, 4'b0100, 1);
        drive(0, 4'b0110, 4'b0000, 1);
        drive(0, 4'b0110, 4'b0000, 1);

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 59) == 0),
                  N'($urandom_range(0, 15)),
                  N'($urandom | $urandom),
                  ($urandom_range(0, 3) != 0));
        end
        drive(0, 4'b0000, 4'b0000, 0);

        @(negedge clk);
        #4;
        checks++;
        if (exp_q.size() == 0 && exp2_q.size() == 0) passes++;
        else $display("FAIL drain got=%0d/%0d exp=0/0 pending entries", exp_q.size(), exp2_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_lock.md
Name: rr_arbiter_lock

Overview:
- Parametrised N-way round-robin arbiter for router output-port and VC allocation.
- Generalises the 2-input rr_arbiter to N_REQ requesters.
- Adds wormhole packet locking: a granted requester keeps the grant until its tail beat.
- Adds an optional hold limit that forces a release.

Parameters:
- N_REQ, 4: number of requesters; must be at least 2.
- IDX_W, $clog2(N_REQ): width of the grant index; derived, do not override.
- MAX_HOLD, 0: maximum accepted beats per ownership; 0 means unlimited.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- arst  in  1  reset; synchronous, active-high.
- req_i  in  N_REQ  per-requester request.
- lock_i  in  N_REQ  per-requester "more beats follow"; high on every non-tail beat of a packet.
- update_i  in  1  current grant accepted this cycle; advances arbitration state.
- grant_o  out  N_REQ  one-hot grant, or all zeros.
- grant_idx_o  out  IDX_W  index of the granted requester; 0 when grant_valid_o=0.
- grant_valid_o  out  1  equals |grant_o.
- locked_o  out  1  arbiter is in LOCKED state.
- forced_release_o  out  1  one-cycle pulse when MAX_HOLD forces a release.

Behaviour:
- State: st_q (IDLE/LOCKED), mask_q[N_REQ], owner_q[IDX_W], hold_q (counter sized for MAX_HOLD), frc_q.
- Reset (arst=1 at an edge):
  - st_q=IDLE, mask_q=all ones, owner_q=0, hold_q=0, frc_q=0.
  - While arst=1, grant_o, grant_idx_o, grant_valid_o, locked_o and forced_release_o are all 0.
- IDLE grant (combinational, zero-latency from req_i):
  - masked = req_i & mask_q.
  - g = lowest set index of masked if masked!=0, else lowest set index of req_i.
  - grant_o = onehot(g) if req_i!=0, else 0.
- LOCKED grant: grant_o = onehot(owner_q) & {N_REQ{req_i[owner_q]}}.
  - Owner deasserting req stalls with grant_o=0; the arbiter stays LOCKED and other requesters are never granted.
- update_i is ignored (no state change) when grant_valid_o=0.
- Accept in IDLE (update_i=1, grant to g):
  - mask_q[k]=1 for k>g, 0 otherwise. g=N_REQ-1 gives all zeros, so the next pick wraps to the lowest requester.
  - If lock_i[g]=1 and (MAX_HOLD==0 or MAX_HOLD>1): st_q=LOCKED, owner_q=g, hold_q=1.
  - Otherwise stay IDLE.
- Accept in LOCKED (update_i=1, owner granted):
  - lock_i[owner_q]=0 (tail beat): st_q=IDLE, hold_q=0.
  - Else if MAX_HOLD!=0 and hold_q+1==MAX_HOLD: st_q=IDLE, hold_q=0, frc_q=1.
  - Else hold_q=hold_q+1.
  - mask_q is unchanged in LOCKED; it was set at lock entry, so the next pick starts above the owner.
- forced_release_o = frc_q. frc_q is cleared on every cycle in which it is not being set.
- MAX_HOLD=1 behaves as a plain round-robin arbiter: no lock is ever entered and no forced release occurs.
- lock_i bits of non-granted requesters have no effect.
- Reset overrides every other event in the same cycle.
- Fairness: with all requesters continuously requesting and lock_i=0, each is granted exactly once per N_REQ accepts.
- Width: hold_q must not wrap for any MAX_HOLD up to 2^16; when MAX_HOLD=0, hold_q saturates.

Test Plan (N_REQ=4 unless stated):
- Reset, req_i=4'b1111, lock_i=0, update_i=1 every cycle -> grant_o sequence 0001, 0010, 0100, 1000, 0001; grant_idx_o 0,1,2,3,0.
- req_i=4'b1010 held, update each cycle -> 0010, 1000, 0010; then drop req_i to 0 with update_i=1 -> grant_valid_o=0, next grant with req_i=4'b1010 is 1000.
- req_i=4'b0011, lock_i[0]=1 for 3 accepts then 0 on the 4th -> grant_o=0001 for 4 accepts with locked_o=1 on accepts 2-4, then 0010 and locked_o=0.
- During the lock, req_i[0]=0 for 2 cycles with update_i=1 -> grant_o=0000, locked_o stays 1, no hold_q change; req_i[0] returns -> 0001 resumes.
- MAX_HOLD=2, req_i=4'b0011, lock_i=4'b0001 held -> grants 0001, 0001, then forced_release_o=1 for one cycle and grant_o=0010.
- Reset asserted while LOCKED on owner 2 -> all outputs 0 during reset; after release with req_i=4'b0110 -> grant_o=0010, locked_o=0.
